// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and memory.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic [31:0]           rsp_data;
  logic                  rsp_error;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_error
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_error
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: issues word fetches, packs {error, pc, instr}
// into a one-entry output register, and handles redirects/flushes of in-flight requests.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_unit_if.master          mem,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  full,
  output logic [ADDR_WIDTH+32:0] data_o,
  output logic                  valid_o
);
  localparam int unsigned DATA_W = ADDR_WIDTH + 33;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] req_pc_q;
  logic [DATA_W-1:0]     data_q;
  logic                  valid_q;

  logic [ADDR_WIDTH-1:0] pc_inc_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_d;
  logic                  slot_free_c;
  logic                  req_valid_c;
  logic                  handshake_c;

  // Only issue when the eventual response is guaranteed a free output slot.
  assign slot_free_c   = !valid_q || !full;
  assign req_valid_c   = !rst && (state_q == IDLE) && !redirect_i && slot_free_c;
  assign handshake_c   = req_valid_c && mem.req_ready;
  assign pc_inc_d      = pc_q + ADDR_WIDTH'(4);
  assign redirect_pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};

  assign mem.req_valid = req_valid_c;
  assign mem.req_addr  = pc_q;
  assign data_o        = data_q;
  assign valid_o       = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else if (redirect_i) begin
      pc_q    <= redirect_pc_d;
      valid_q <= 1'b0;
      // An outstanding request must have its stale response swallowed in FLUSH.
      unique case (state_q)
        WAIT:    state_q <= mem.rsp_valid ? IDLE : FLUSH;
        FLUSH:   state_q <= mem.rsp_valid ? IDLE : FLUSH;
        default: state_q <= IDLE;
      endcase
    end else begin
      if (valid_q && !full) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (handshake_c) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_inc_d;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (mem.rsp_valid) begin
            valid_q <= 1'b1;
            data_q  <= {mem.rsp_error, req_pc_q, mem.rsp_data};
            state_q <= mem.rsp_error ? HALT : IDLE;
          end
        end
        FLUSH: begin
          if (mem.rsp_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: main instance at RESET_PC=0, second instance checks PC wrap.
module tb_fetch_unit;
  logic clk;
  logic rst;
  logic redirect_i;
  logic [31:0] redirect_pc_i;
  logic full;
  logic [64:0] data_o;
  logic valid_o;

  logic w_redirect;
  logic [31:0] w_redirect_pc;
  logic [64:0] w_data;
  logic w_valid;

  int total;
  int bad;

  fetch_unit_if #(.ADDR_WIDTH(32)) mem_if ();
  fetch_unit_if #(.ADDR_WIDTH(32)) w_if ();

  fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .mem(mem_if.master),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .full(full), .data_o(data_o), .valid_o(valid_o)
  );

  fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .mem(w_if.master),
    .redirect_i(w_redirect), .redirect_pc_i(w_redirect_pc),
    .full(full), .data_o(w_data), .valid_o(w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_i = 1'b0;
    full = 1'b0;
    mem_if.rsp_valid = 1'b0;
    mem_if.rsp_error = 1'b0;
    w_if.rsp_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++;
    if (mem_if.req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", mem_if.req_valid); end
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid_o got=%b exp=0", valid_o); end
    total++;
    if (data_o !== 65'h0) begin bad++; $display("FAIL reset_data_o got=%h exp=0", data_o); end
    rst = 1'b0;
    #1;
    total++;
    if (mem_if.req_valid !== 1'b1 || mem_if.req_addr !== 32'h0) begin
      bad++; $display("FAIL first_req got=%b/%h exp=1/0", mem_if.req_valid, mem_if.req_addr);
    end
  endtask

  task automatic test_stream();
    logic [64:0] exp;
    do_reset();
    tick();
    mem_if.rsp_valid = 1'b1; mem_if.rsp_data = 32'h1111_0000;
    #1;
    total++;
    if (mem_if.req_valid !== 1'b0) begin bad++; $display("FAIL stream_wait_req got=%b exp=0", mem_if.req_valid); end
    tick();
    mem_if.rsp_valid = 1'b0;
    #1;
    exp = {1'b0, 32'h0, 32'h1111_0000};
    total++;
    if (valid_o !== 1'b1 || data_o !== exp) begin bad++; $display("FAIL stream_pkt0 got=%b/%h exp=1/%h", valid_o, data_o, exp); end
    total++;
    if (mem_if.req_valid !== 1'b1 || mem_if.req_addr !== 32'h4) begin
      bad++; $display("FAIL stream_req1 got=%b/%h exp=1/4", mem_if.req_valid, mem_if.req_addr);
    end
    tick();
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", valid_o); end
    mem_if.rsp_valid = 1'b1; mem_if.rsp_data = 32'h2222_0001;
    tick();
    mem_if.rsp_valid = 1'b0;
    #1;
    exp = {1'b0, 32'h4, 32'h2222_0001};
    total++;
    if (valid_o !== 1'b1 || data_o !== exp) begin bad++; $display("FAIL stream_pkt1 got=%b/%h exp=1/%h", valid_o, data_o, exp); end
    total++;
    if (mem_if.req_valid !== 1'b1 || mem_if.req_addr !== 32'h8) begin
      bad++; $display("FAIL stream_req2 got=%b/%h exp=1/8", mem_if.req_valid, mem_if.req_addr);
    end
  endtask

  task automatic test_backpressure();
    logic [64:0] exp;
    do_reset();
    tick();
    mem_if.rsp_valid = 1'b1; mem_if.rsp_data = 32'hCAFE_0000;
    full = 1'b1;
    tick();
    mem_if.rsp_valid = 1'b0;
    exp = {1'b0, 32'h0, 32'hCAFE_0000};
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (valid_o !== 1'b1 || data_o !== exp || mem_if.req_valid !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/%h/0", i, valid_o, data_o, mem_if.req_valid, exp);
      end
      tick();
    end
    full = 1'b0;
    #1;
    total++;
    if (mem_if.req_valid !== 1'b1 || mem_if.req_addr !== 32'h4) begin
      bad++; $display("FAIL bp_release_req got=%b/%h exp=1/4", mem_if.req_valid, mem_if.req_addr);
    end
    tick();
    total++;
    if (valid_o !== 1'b0 || mem_if.req_valid !== 1'b0) begin
      bad++; $display("FAIL bp_after_xfer got=%b/%b exp=0/0", valid_o, mem_if.req_valid);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h103;
    #1;
    total++;
    if (mem_if.req_valid !== 1'b0) begin bad++; $display("FAIL redir_req_block got=%b exp=0", mem_if.req_valid); end
    tick();
    redirect_i = 1'b0;
    mem_if.rsp_valid = 1'b1; mem_if.rsp_data = 32'hBAD0_BAD0;
    #1;
    total++;
    if (mem_if.req_valid !== 1'b0) begin bad++; $display("FAIL redir_flush_req got=%b exp=0", mem_if.req_valid); end
    tick();
    mem_if.rsp_valid = 1'b0;
    #1;
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("FAIL redir_stale_pkt got=%b exp=0", valid_o); end
    total++;
    if (mem_if.req_valid !== 1'b1 || mem_if.req_addr !== 32'h100) begin
      bad++; $display("FAIL redir_target got=%b/%h exp=1/100", mem_if.req_valid, mem_if.req_addr);
    end
  endtask

  task automatic test_redirect_discard();
    do_reset();
    tick();
    mem_if.rsp_valid = 1'b1; mem_if.rsp_data = 32'h5555_AAAA;
    full = 1'b1;
    tick();
    mem_if.rsp_valid = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    tick();
    redirect_i = 1'b0; full = 1'b0;
    #1;
    total++;
    if (valid_o !== 1'b0 || mem_if.req_valid !== 1'b1 || mem_if.req_addr !== 32'h40) begin
      bad++; $display("FAIL redir_full_discard got=%b/%b/%h exp=0/1/40", valid_o, mem_if.req_valid, mem_if.req_addr);
    end
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h207;
    mem_if.rsp_valid = 1'b1; mem_if.rsp_data = 32'h7777_7777;
    tick();
    redirect_i = 1'b0; mem_if.rsp_valid = 1'b0;
    #1;
    total++;
    if (valid_o !== 1'b0 || mem_if.req_valid !== 1'b1 || mem_if.req_addr !== 32'h204) begin
      bad++; $display("FAIL redir_same_rsp got=%b/%b/%h exp=0/1/204", valid_o, mem_if.req_valid, mem_if.req_addr);
    end
  endtask

  task automatic test_error();
    logic [64:0] exp;
    do_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'h20;
    tick();
    redirect_i = 1'b0;
    #1;
    total++;
    if (mem_if.req_addr !== 32'h20) begin bad++; $display("FAIL err_pc got=%h exp=20", mem_if.req_addr); end
    tick();
    mem_if.rsp_valid = 1'b1; mem_if.rsp_error = 1'b1; mem_if.rsp_data = 32'hDEAD_BEEF;
    tick();
    mem_if.rsp_valid = 1'b0; mem_if.rsp_error = 1'b0;
    #1;
    exp = {1'b1, 32'h20, 32'hDEAD_BEEF};
    total++;
    if (valid_o !== 1'b1 || data_o !== exp) begin bad++; $display("FAIL err_pkt got=%b/%h exp=1/%h", valid_o, data_o, exp); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (mem_if.req_valid !== 1'b0) begin bad++; $display("FAIL err_halt%0d got=%b exp=0", i, mem_if.req_valid); end
      tick();
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h80;
    tick();
    redirect_i = 1'b0;
    #1;
    total++;
    if (mem_if.req_valid !== 1'b1 || mem_if.req_addr !== 32'h80) begin
      bad++; $display("FAIL err_resume got=%b/%h exp=1/80", mem_if.req_valid, mem_if.req_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    total++;
    if (w_if.req_valid !== 1'b1 || w_if.req_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_first got=%b/%h exp=1/fffffffc", w_if.req_valid, w_if.req_addr);
    end
    tick();
    w_if.rsp_valid = 1'b1; w_if.rsp_data = 32'h0BAD_F00D;
    tick();
    w_if.rsp_valid = 1'b0;
    #1;
    total++;
    if (w_if.req_valid !== 1'b1 || w_if.req_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_second got=%b/%h exp=1/0", w_if.req_valid, w_if.req_addr);
    end
    total++;
    if (w_valid !== 1'b1 || w_data !== {1'b0, 32'hFFFF_FFFC, 32'h0BAD_F00D}) begin
      bad++; $display("FAIL wrap_pkt got=%b/%h", w_valid, w_data);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'h300;
    tick();
    redirect_i = 1'b0;
    tick();
    rst = 1'b1;
    mem_if.rsp_valid = 1'b1; mem_if.rsp_data = 32'h1234_5678;
    #1;
    total++;
    if (mem_if.req_valid !== 1'b0) begin bad++; $display("FAIL rstwait_req got=%b exp=0", mem_if.req_valid); end
    tick();
    rst = 1'b0; mem_if.rsp_valid = 1'b0;
    #1;
    total++;
    if (valid_o !== 1'b0 || mem_if.req_valid !== 1'b1 || mem_if.req_addr !== 32'h0) begin
      bad++; $display("FAIL rstwait_release got=%b/%b/%h exp=0/1/0", valid_o, mem_if.req_valid, mem_if.req_addr);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    full = 1'b0;
    mem_if.req_ready = 1'b1;
    mem_if.rsp_valid = 1'b0;
    mem_if.rsp_data = 32'h0;
    mem_if.rsp_error = 1'b0;
    w_redirect = 1'b0;
    w_redirect_pc = 32'h0;
    w_if.req_ready = 1'b1;
    w_if.rsp_valid = 1'b0;
    w_if.rsp_data = 32'h0;
    w_if.rsp_error = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_discard();
    test_error();
    test_wrap();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
